// File: rtl/jogo_sequencia_param_if.sv
// Signal bundle between the player/board side and the sequence-memory game engine.
// The slave modport is the engine; the master modport drives buttons and level selects.
interface jogo_sequencia_param_if #(
  parameter int N_BOTOES    = 4,
  parameter int MAX_RODADAS = 16
);
  localparam int W_R = $clog2(MAX_RODADAS + 1);

  logic                iniciar;
  logic [N_BOTOES-1:0] botoes;
  logic                nivel_rodadas;
  logic                nivel_tempo;
  logic [N_BOTOES-1:0] leds;
  logic                vez_jogador;
  logic                nova_jogada;
  logic                ganhou;
  logic                perdeu;
  logic                pronto;
  logic [3:0]          db_estado;
  logic [W_R-1:0]      db_rodada;
  logic                db_timeout;

  modport master (
    output iniciar, botoes, nivel_rodadas, nivel_tempo,
    input  leds, vez_jogador, nova_jogada, ganhou, perdeu, pronto,
           db_estado, db_rodada, db_timeout
  );

  modport slave (
    input  iniciar, botoes, nivel_rodadas, nivel_tempo,
    output leds, vez_jogador, nova_jogada, ganhou, perdeu, pronto,
           db_estado, db_rodada, db_timeout
  );
endinterface

// File: rtl/jogo_sequencia_param.sv
// Simon-style sequence-memory game: LFSR-generated one-hot elements are appended each round,
// replayed on the LEDs and then checked against edge-detected player moves.
module jogo_sequencia_param #(
  parameter int          N_BOTOES    = 4,
  parameter int          MAX_RODADAS = 16,
  parameter int          CLOCK_FREQ  = 5000,
  parameter int          T_LED       = CLOCK_FREQ / 2,
  parameter int          T_TIMEOUT   = 3 * CLOCK_FREQ,
  parameter logic [15:0] SEMENTE     = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  reset,
  jogo_sequencia_param_if.slave bus
);
  localparam int W_R   = $clog2(MAX_RODADAS + 1);
  localparam int W_I   = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;
  localparam int T_MAX = (T_LED > T_TIMEOUT) ? T_LED : T_TIMEOUT;
  localparam int W_T   = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    INICIAL   = 4'h0,
    PREPARA   = 4'h1,
    GERA      = 4'h2,
    MOSTRA    = 4'h3,
    INTERVALO = 4'h4,
    ESPERA    = 4'h5,
    REGISTRA  = 4'h6,
    COMPARA   = 4'h7,
    GANHOU    = 4'hA,
    PERDEU    = 4'hB,
    TIMEOUT   = 4'hC
  } estado_t;

  estado_t             r_estado;
  estado_t             w_estado_next;
  logic [15:0]         r_lfsr;
  logic [N_BOTOES-1:0] r_mem [MAX_RODADAS];
  logic [W_R-1:0]      r_rodada;
  logic [W_I-1:0]      r_indice;
  logic [W_T-1:0]      r_timer;
  logic [N_BOTOES-1:0] r_valor;
  logic [N_BOTOES-1:0] r_botoes_q;
  logic [N_BOTOES-1:0] r_leds;
  logic                r_nivel_rod;
  logic                r_nivel_tempo;
  logic                r_vez;
  logic                r_nova;
  logic                r_ganhou;
  logic                r_perdeu;
  logic                r_pronto;
  logic                r_timeout;

  logic                w_fb;
  logic [N_BOTOES-1:0] w_elem;
  logic [N_BOTOES-1:0] w_mem_atual;
  logic [W_R-1:0]      w_limite;
  logic                w_evento;
  logic                w_ultimo;
  logic                w_fim_led;
  logic                w_fim_tempo;

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign w_fb        = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_elem      = N_BOTOES'(1) << (r_lfsr % 16'(N_BOTOES));
  assign w_mem_atual = r_mem[r_indice];
  assign w_limite    = r_nivel_rod ? W_R'(MAX_RODADAS) : W_R'(MAX_RODADAS / 2);
  assign w_evento    = (|bus.botoes) & ~(|r_botoes_q);
  assign w_ultimo    = (W_R'(r_indice) == r_rodada - W_R'(1));
  assign w_fim_led   = (r_timer == W_T'(T_LED - 1));
  assign w_fim_tempo = (r_timer == W_T'(T_TIMEOUT - 1));

  always_comb begin
    w_estado_next = r_estado;
    case (r_estado)
      INICIAL:   if (bus.iniciar) w_estado_next = PREPARA;
      PREPARA:   w_estado_next = GERA;
      GERA:      w_estado_next = MOSTRA;
      MOSTRA:    if (w_fim_led) w_estado_next = INTERVALO;
      INTERVALO: if (w_fim_led) w_estado_next = w_ultimo ? ESPERA : MOSTRA;
      // a move arriving on the expiry cycle still counts as a move
      ESPERA: begin
        if (w_evento) w_estado_next = REGISTRA;
        else if (r_nivel_tempo && w_fim_tempo) w_estado_next = TIMEOUT;
      end
      REGISTRA:  w_estado_next = COMPARA;
      COMPARA: begin
        if (r_valor != w_mem_atual) w_estado_next = PERDEU;
        else if (w_ultimo) w_estado_next = (r_rodada == w_limite) ? GANHOU : GERA;
        else w_estado_next = ESPERA;
      end
      GANHOU, PERDEU, TIMEOUT: if (bus.iniciar) w_estado_next = PREPARA;
      default:   w_estado_next = INICIAL;
    endcase
  end

  // Sequence memory has no reset: entries are always written before being read
  always_ff @(posedge clock) begin
    if (r_estado == GERA) r_mem[W_I'(r_rodada)] <= w_elem;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado      <= INICIAL;
      r_lfsr        <= SEMENTE;
      r_rodada      <= '0;
      r_indice      <= '0;
      r_timer       <= '0;
      r_valor       <= '0;
      r_botoes_q    <= '0;
      r_leds        <= '0;
      r_nivel_rod   <= 1'b0;
      r_nivel_tempo <= 1'b0;
      r_vez         <= 1'b0;
      r_nova        <= 1'b0;
      r_ganhou      <= 1'b0;
      r_perdeu      <= 1'b0;
      r_pronto      <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_lfsr     <= {w_fb, r_lfsr[15:1]};
      r_botoes_q <= bus.botoes;
      r_estado   <= w_estado_next;
      r_vez      <= (w_estado_next == ESPERA);
      r_nova     <= (w_estado_next == GERA);
      r_ganhou   <= (w_estado_next == GANHOU);
      r_perdeu   <= (w_estado_next == PERDEU) || (w_estado_next == TIMEOUT);
      r_pronto   <= (w_estado_next == GANHOU) || (w_estado_next == PERDEU) ||
                    (w_estado_next == TIMEOUT);
      r_timeout  <= (w_estado_next == TIMEOUT);

      // one timer serves LED on/off phases and the per-move timeout
      if (w_estado_next != r_estado) r_timer <= '0;
      else if (r_estado == MOSTRA || r_estado == INTERVALO ||
               (r_estado == ESPERA && r_nivel_tempo)) r_timer <= r_timer + W_T'(1);

      case (r_estado)
        PREPARA: begin
          r_rodada      <= '0;
          r_indice      <= '0;
          r_nivel_rod   <= bus.nivel_rodadas;
          r_nivel_tempo <= bus.nivel_tempo;
        end
        GERA: begin
          r_rodada <= r_rodada + W_R'(1);
          r_indice <= '0;
        end
        INTERVALO: begin
          if (w_estado_next == MOSTRA) r_indice <= r_indice + W_I'(1);
          else if (w_estado_next == ESPERA) r_indice <= '0;
        end
        ESPERA:  if (w_estado_next == REGISTRA) r_valor <= bus.botoes;
        COMPARA: if (w_estado_next == ESPERA) r_indice <= r_indice + W_I'(1);
        default: ;
      endcase

      // element 0 of round 1 is still being written while MOSTRA is entered
      if (w_estado_next == MOSTRA) begin
        if (r_estado == GERA) r_leds <= (r_rodada == '0) ? w_elem : r_mem[0];
        else if (r_estado == INTERVALO) r_leds <= r_mem[r_indice + W_I'(1)];
      end else if (w_estado_next == ESPERA) begin
        r_leds <= bus.botoes;
      end else begin
        r_leds <= '0;
      end
    end
  end

  assign bus.leds        = r_leds;
  assign bus.vez_jogador = r_vez;
  assign bus.nova_jogada = r_nova;
  assign bus.ganhou      = r_ganhou;
  assign bus.perdeu      = r_perdeu;
  assign bus.pronto      = r_pronto;
  assign bus.db_estado   = r_estado;
  assign bus.db_rodada   = r_rodada;
  assign bus.db_timeout  = r_timeout;
endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Self-checking bench for jogo_sequencia_param: a reference LFSR/sequence model predicts each
// appended element, and randomised games are played against it.
module tb_jogo_sequencia_param;
  logic clock = 1'b0;
  logic reset;

  jogo_sequencia_param_if #(.N_BOTOES(4), .MAX_RODADAS(4)) bus ();

  jogo_sequencia_param #(
    .N_BOTOES(4), .MAX_RODADAS(4), .CLOCK_FREQ(10), .T_LED(5), .T_TIMEOUT(20), .SEMENTE(16'hACE1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int n_nova   = 0;
  logic [15:0] m_lfsr;
  logic [3:0]  seq[$];
  logic [3:0]  shown[$];
  logic [3:0]  prev_st;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR built from its tap list (taps 16,14,13,11 of a right-shifting register)
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[t]) fb ^= s[16 - taps[t]];
    return {fb, s[15:1]};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  // Sequence model: each nova_jogada appends one-hot(lfsr mod 4); record what MOSTRA displays
  always @(negedge clock) begin
    if (bus.nova_jogada === 1'b1) begin
      seq.push_back(4'b0001 << (m_lfsr % 4));
      n_nova <= n_nova + 1;
    end
    if (bus.db_estado == 4'h3 && prev_st != 4'h3) shown.push_back(bus.leds);
    prev_st <= bus.db_estado;
  end

  task automatic wait_st(input logic [3:0] s, input int budget);
    int n = 0;
    while (bus.db_estado !== s && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (bus.db_estado !== s) check_eq("wait_state", bus.db_estado, s);
  endtask

  task automatic start_game();
    seq.delete();
    shown.delete();
    n_nova = 0;
    @(negedge clock);
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
  endtask

  task automatic reset_start();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    start_game();
  endtask

  // Press at a negedge in ESPERA; sample state two and three clocks later
  task automatic press(input logic [3:0] v, output logic [3:0] st2, output logic p2,
                       output logic [3:0] st3, output logic p3);
    bus.botoes = v;
    repeat (2) @(posedge clock);
    #1;
    st2 = bus.db_estado;
    p2  = bus.perdeu;
    @(posedge clock);
    #1;
    st3 = bus.db_estado;
    p3  = bus.perdeu;
    if (st3 == 4'h2) shown.delete();
    @(negedge clock);
    bus.botoes = '0;
    @(negedge clock);
  endtask

  task automatic play(input int limite, input int n_rounds, input int wrong_round);
    logic [3:0] v, exp_st, st2, st3;
    logic p2, p3;
    for (int r = 1; r <= n_rounds; r++) begin
      wait_st(4'h5, 100 * r + 100);
      check_eq("round_len", seq.size(), r);
      check_eq("db_rodada", bus.db_rodada, r);
      check_eq("vez_jogador", bus.vez_jogador, 1);
      check_eq("replay_len", shown.size(), r);
      for (int i = 0; i < shown.size() && i < seq.size(); i++) check_eq("replay", shown[i], seq[i]);
      for (int i = 0; i < r; i++) begin
        wait_st(4'h5, 50);
        v = (i < seq.size()) ? seq[i] : 4'b0001;
        if (r == wrong_round && i == r - 1) begin
          v = {v[2:0], v[3]};
          exp_st = 4'hB;
        end else if (i < r - 1) exp_st = 4'h5;
        else if (r == limite) exp_st = 4'hA;
        else exp_st = 4'h2;
        press(v, st2, p2, st3, p3);
        $display("move round=%0d idx=%0d buttons=%b state=%h want=%h", r, i, v, st3, exp_st);
        check_eq("compara_latency", st2, 4'h7);
        check_eq("move_result", st3, exp_st);
        if (exp_st == 4'hB) begin
          check_eq("perdeu_k2", p2, 0);
          check_eq("perdeu_k3", p3, 1);
          return;
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] st2, st3, l1, e0;
    logic p2, p3;
    int n;
    reset = 1'b1;
    bus.iniciar = 1'b0;
    bus.botoes = '0;
    bus.nivel_rodadas = 1'b0;
    bus.nivel_tempo = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_estado", bus.db_estado, 0);
    check_eq("rst_leds", bus.leds, 0);
    check_eq("rst_flags", {bus.vez_jogador, bus.nova_jogada, bus.ganhou, bus.perdeu,
                           bus.pronto, bus.db_timeout}, 0);
    check_eq("rst_rodada", bus.db_rodada, 0);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    check_eq("idle_estado", bus.db_estado, 0);
    check_eq("idle_leds", bus.leds, 0);
    check_eq("idle_pronto", bus.pronto, 0);

    // short game won
    bus.nivel_rodadas = 1'b0;
    repeat ($urandom_range(7)) @(negedge clock);
    start_game();
    play(2, 2, 0);
    check_eq("win_nova_count", n_nova, 2);
    check_eq("win_estado", bus.db_estado, 4'hA);
    check_eq("win_ganhou", bus.ganhou, 1);
    check_eq("win_pronto", bus.pronto, 1);
    check_eq("win_perdeu", bus.perdeu, 0);
    check_eq("win_rodada", bus.db_rodada, 2);

    // long game lost in round 3
    bus.nivel_rodadas = 1'b1;
    repeat ($urandom_range(7)) @(negedge clock);
    start_game();
    play(4, 3, 3);
    check_eq("lose_perdeu", bus.perdeu, 1);
    check_eq("lose_ganhou", bus.ganhou, 0);
    check_eq("lose_rodada", bus.db_rodada, 3);
    check_eq("lose_estado", bus.db_estado, 4'hB);

    // timeout enabled, nobody plays
    bus.nivel_rodadas = 1'b0;
    bus.nivel_tempo = 1'b1;
    start_game();
    wait_st(4'h5, 200);
    n = 0;
    while (bus.db_estado == 4'h5 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check_eq("timeout_cycles", n, 20);
    check_eq("timeout_estado", bus.db_estado, 4'hC);
    check_eq("timeout_flag", bus.db_timeout, 1);
    check_eq("timeout_perdeu", bus.perdeu, 1);

    // timeout disabled at start; raising nivel_tempo mid-game must not arm it
    bus.nivel_tempo = 1'b0;
    start_game();
    wait_st(4'h5, 200);
    bus.nivel_tempo = 1'b1;
    repeat (200) @(negedge clock);
    check_eq("no_timeout_estado", bus.db_estado, 4'h5);
    check_eq("no_timeout_flag", bus.db_timeout, 0);
    bus.nivel_tempo = 1'b0;

    // multi-hot move always loses
    press(4'b0011, st2, p2, st3, p3);
    $display("move round=1 idx=0 buttons=0011 state=%h want=b", st3);
    check_eq("multihot_result", st3, 4'hB);

    // button held from INTERVALO into ESPERA registers no move
    start_game();
    wait_st(4'h4, 200);
    e0 = (seq.size() > 0) ? seq[0] : 4'b0001;
    bus.botoes = e0;
    wait_st(4'h5, 100);
    repeat (30) @(negedge clock);
    check_eq("held_no_move", bus.db_estado, 4'h5);
    bus.botoes = '0;
    @(negedge clock);
    press(e0, st2, p2, st3, p3);
    $display("move round=1 idx=0 buttons=%b state=%h want=2", e0, st3);
    check_eq("after_release_move", st3, 4'h2);

    // reset during MOSTRA, then restart with identical timing
    reset_start();
    wait_st(4'h3, 100);
    l1 = bus.leds;
    check_eq("first_elem_model", l1, (seq.size() > 0) ? seq[0] : 4'hx);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_estado", bus.db_estado, 0);
    check_eq("async_rst_leds", bus.leds, 0);
    check_eq("async_rst_rodada", bus.db_rodada, 0);
    check_eq("async_rst_flags", {bus.vez_jogador, bus.nova_jogada, bus.ganhou, bus.perdeu,
                                 bus.pronto, bus.db_timeout}, 0);
    reset_start();
    wait_st(4'h3, 100);
    check_eq("restart_same_elem", bus.leds, l1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
